plab5_mcore_proc2mem_trans_buf: RTL and testbench
=================================================

# plab5_mcore_proc2mem_trans_buf

Parametrised, buffered translator between one processor-width memory port and one cache-line-width memory port, with val/rdy handshakes on all four message channels. Reads are issued as full line-aligned line reads, and the requested word is extracted from the returned line. Writes carry a translated length and zero-padded data. An in-order tracking FIFO of configurable depth records per-request word offset and length. The block sits between a core (or L1 port) and the line-width memory/network in the multicore tile.

## Interface

**Parameters**

- `opaque_nbits`, 8, opaque field width (`o`).
- `addr_nbits`, 32, address width (`a`).
- `proc_data_nbits`, 32, processor data width (`pd`); multiple of 8.
- `mem_data_nbits`, 128, memory data width (`md`); `md/pd` is a power of two ≥1.
- `num_entries`, 4, tracking FIFO depth; power of two ≥2.
- Derived widths:
  - `wo = clog2(md/pd)` word-offset bits.
  - `bo = clog2(pd/8)` byte-in-word bits.
  - `lo = wo+bo` line-offset bits.
  - `cnt_nbits = clog2(num_entries)+1`.
- Message widths `VC_MEM_REQ_MSG_NBITS` / `VC_MEM_RESP_MSG_NBITS` with (o,a,pd) on the proc side and (o,a,md) on the mem side.

**Ports**

- `clk` in 1: clock.
- `reset` in 1: **synchronous, active-low**; `reset==0` at a rising edge resets.
- `proc_req_val` in 1 / `proc_req_rdy` out 1 / `proc_req_msg` in proc_reqmsg_nbits: processor request.
- `mem_req_val` out 1 / `mem_req_rdy` in 1 / `mem_req_msg` out mem_reqmsg_nbits: memory request.
- `mem_resp_val` in 1 / `mem_resp_rdy` out 1 / `mem_resp_msg` in mem_respmsg_nbits: memory response.
- `proc_resp_val` out 1 / `proc_resp_rdy` in 1 / `proc_resp_msg` out proc_respmsg_nbits: processor response.
- `num_outstanding` out cnt_nbits: current tracking FIFO occupancy.

## Operation

**Request path** (combinational pass-through, gated by the FIFO):
- `mem_req_val = proc_req_val & !full & reset`.
- `proc_req_rdy = mem_req_rdy & !full & reset`.
- Request fire = `mem_req_val & mem_req_rdy`; it pushes `{word_off = addr[lo-1:bo], plen = proc len}` into the FIFO.

**Read** (type 0):
- type and opaque are copied.
- addr = proc addr with `[lo-1:0]` cleared.
- len = 0 (full line).
- data = all zeros.

**Write** (type 1):
- type, opaque and addr are copied unchanged.
- len = `pd/8` when proc len==0, else the proc len value, zero-extended.
- data = `{(md-pd)'b0, proc data}`; no X bits are ever driven.

**Other types:** handled as writes (pass-through, zero-padded).

**Response path:**
- `proc_resp_val = mem_resp_val & !empty & reset`.
- `mem_resp_rdy = proc_resp_rdy & !empty & reset`.
- Response fire pops the FIFO head.
- proc_resp fields:
  - type and opaque are copied from mem_resp.
  - len = head `plen`.
  - data = `mem_resp data[head.word_off*pd +: pd]` when type==0, else 0.

**Ordering and FIFO rules:**
- Responses are in order; the FIFO head always belongs to the oldest request.
- A response arriving while the FIFO is empty is never accepted (`mem_resp_rdy=0`); it stalls until an entry exists.
- Full blocks new requests even if a pop occurs in the same cycle. There is no comb path from the response channel to the request channel.
- Simultaneous push and pop (not full, not empty): occupancy unchanged, both pointers advance.
- Pointers are `clog2(num_entries)` bits and wrap modulo `num_entries`.
- full = `count==num_entries`; empty = `count==0`.

## Timing

- Request and response translation: 0-cycle latency (combinational). The FIFO updates at the clock edge following a fire.
- Reset (`reset==0` at edge): pointers and count cleared. All in-flight tracking state is discarded; responses for discarded requests are not expected afterward.
- While `reset==0`: `mem_req_val`, `proc_req_rdy`, `mem_resp_rdy` and `proc_resp_val` are all 0.
- After reset: `num_outstanding=0`, `proc_resp_val=0`, `proc_req_rdy` follows `mem_req_rdy`.
- Val must never depend on rdy of the same channel. Messages are stable only when val=1.

## Test plan

1. Read, addr 0x00001008, opaque 0x05 -> mem_req addr 0x00001000, len 0, data 0. Response data 128'h44444444_33333333_22222222_11111111 -> proc_resp data 0x33333333, opaque 0x05, len 0.
2. Write, addr 0x00002004, len 0, data 0xDEADBEEF -> mem_req addr 0x00002004, len 4, data {96'h0,32'hDEADBEEF}. Write response -> proc_resp type 1, data 0, len 0.
3. Four reads to word offsets 0,1,2,3 with `mem_resp_val=0` -> `num_outstanding=4`, then `proc_req_rdy=0` even with `mem_req_rdy=1`. Return four responses -> words extracted in order by offset, count returns to 0, and pointers have wrapped.
4. `mem_resp_val=1` with FIFO empty -> `mem_resp_rdy=0`, `proc_resp_val=0`. Then issue a read -> the response is accepted the cycle after the push.
5. Backpressure: `proc_resp_rdy=0` for 3 cycles with one response pending -> `mem_resp_rdy=0` and the FIFO holds. On release, exactly one pop occurs. Simultaneous push+pop leaves the count unchanged.
6. Reset asserted low with 2 outstanding -> the next cycle `num_outstanding=0` and all val/rdy outputs are 0 during reset. Run a fresh read after release -> correct extraction.

Source files
------------

// File: rtl/plab5_mcore_proc2mem_trans_buf_if.sv
// rtl/plab5_mcore_proc2mem_trans_buf_if.sv - four val/rdy message channels between core, translator and line-width memory
interface plab5_mcore_proc2mem_trans_buf_if #(
   parameter int opaque_nbits    = 8,
   parameter int addr_nbits      = 32,
   parameter int proc_data_nbits = 32,
   parameter int mem_data_nbits  = 128
);
   localparam int proc_len_nbits      = (proc_data_nbits > 8) ? $clog2(proc_data_nbits / 8) : 1;
   localparam int mem_len_nbits       = (mem_data_nbits > 8) ? $clog2(mem_data_nbits / 8) : 1;
   localparam int proc_reqmsg_nbits   = 3 + opaque_nbits + addr_nbits + proc_len_nbits + proc_data_nbits;
   localparam int mem_reqmsg_nbits    = 3 + opaque_nbits + addr_nbits + mem_len_nbits + mem_data_nbits;
   localparam int mem_respmsg_nbits   = 3 + opaque_nbits + mem_len_nbits + mem_data_nbits;
   localparam int proc_respmsg_nbits  = 3 + opaque_nbits + proc_len_nbits + proc_data_nbits;

   logic                          proc_req_val;
   logic                          proc_req_rdy;
   logic [proc_reqmsg_nbits-1:0]  proc_req_msg;

   logic                          mem_req_val;
   logic                          mem_req_rdy;
   logic [mem_reqmsg_nbits-1:0]   mem_req_msg;

   logic                          mem_resp_val;
   logic                          mem_resp_rdy;
   logic [mem_respmsg_nbits-1:0]  mem_resp_msg;

   logic                          proc_resp_val;
   logic                          proc_resp_rdy;
   logic [proc_respmsg_nbits-1:0] proc_resp_msg;

   modport slave (
      input  proc_req_val, proc_req_msg, output proc_req_rdy,
      output mem_req_val, mem_req_msg, input mem_req_rdy,
      input  mem_resp_val, mem_resp_msg, output mem_resp_rdy,
      output proc_resp_val, proc_resp_msg, input proc_resp_rdy
   );

   modport master (
      output proc_req_val, proc_req_msg, input proc_req_rdy,
      input  mem_req_val, mem_req_msg, output mem_req_rdy,
      output mem_resp_val, mem_resp_msg, input mem_resp_rdy,
      input  proc_resp_val, proc_resp_msg, output proc_resp_rdy
   );
endinterface

// File: rtl/plab5_mcore_proc2mem_trans_buf.sv
// rtl/plab5_mcore_proc2mem_trans_buf.sv - processor-word to cache-line memory translator with in-order tracking FIFO
module plab5_mcore_proc2mem_trans_buf #(
   parameter int opaque_nbits    = 8,
   parameter int addr_nbits      = 32,
   parameter int proc_data_nbits = 32,
   parameter int mem_data_nbits  = 128,
   parameter int num_entries     = 4
)(
   input  logic                           clk,
   input  logic                           reset,
   plab5_mcore_proc2mem_trans_buf_if.slave bus,
   output logic [$clog2(num_entries):0]   num_outstanding
);
   localparam int wo  = $clog2(mem_data_nbits / proc_data_nbits);
   localparam int bo  = $clog2(proc_data_nbits / 8);
   localparam int lo  = wo + bo;
   localparam int wow = (wo > 0) ? wo : 1;
   localparam int plw = (proc_data_nbits > 8) ? $clog2(proc_data_nbits / 8) : 1;
   localparam int mlw = (mem_data_nbits > 8) ? $clog2(mem_data_nbits / 8) : 1;
   localparam int pw  = $clog2(num_entries);
   localparam int cw  = pw + 1;

   localparam logic [addr_nbits-1:0] line_mask = ~((addr_nbits'(1) << lo) - addr_nbits'(1));
   localparam logic [addr_nbits-1:0] off_mask  = addr_nbits'((1 << wo) - 1);

   typedef struct packed {
      logic [2:0]                 typ;
      logic [opaque_nbits-1:0]    opaque;
      logic [addr_nbits-1:0]      addr;
      logic [plw-1:0]             len;
      logic [proc_data_nbits-1:0] data;
   } proc_req_t;

   typedef struct packed {
      logic [2:0]                 typ;
      logic [opaque_nbits-1:0]    opaque;
      logic [addr_nbits-1:0]      addr;
      logic [mlw-1:0]             len;
      logic [mem_data_nbits-1:0]  data;
   } mem_req_t;

   typedef struct packed {
      logic [2:0]                 typ;
      logic [opaque_nbits-1:0]    opaque;
      logic [mlw-1:0]             len;
      logic [mem_data_nbits-1:0]  data;
   } mem_resp_t;

   typedef struct packed {
      logic [2:0]                 typ;
      logic [opaque_nbits-1:0]    opaque;
      logic [plw-1:0]             len;
      logic [proc_data_nbits-1:0] data;
   } proc_resp_t;

   proc_req_t  preq;
   mem_req_t   mreq;
   mem_resp_t  mresp;
   proc_resp_t presp;

   logic [pw-1:0]  wr_ptr;
   logic [pw-1:0]  rd_ptr;
   logic [cw-1:0]  count;
   logic [wow-1:0] off_q  [num_entries];
   logic [plw-1:0] plen_q [num_entries];

   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [wow-1:0] req_off;
   logic [wow-1:0] head_off;

   assign preq  = proc_req_t'(bus.proc_req_msg);
   assign mresp = mem_resp_t'(bus.mem_resp_msg);

   assign full  = (count == cw'(num_entries));
   assign empty = (count == '0);

   // Request side only looks at full, so nothing on the response channel reaches it combinationally.
   assign bus.mem_req_val  = bus.proc_req_val & ~full & reset;
   assign bus.proc_req_rdy = bus.mem_req_rdy & ~full & reset;
   assign push             = bus.mem_req_val & bus.mem_req_rdy;

   assign bus.proc_resp_val = bus.mem_resp_val & ~empty & reset;
   assign bus.mem_resp_rdy  = bus.proc_resp_rdy & ~empty & reset;
   assign pop               = bus.mem_resp_val & bus.mem_resp_rdy;

   assign req_off  = wow'((preq.addr >> bo) & off_mask);
   assign head_off = off_q[rd_ptr];

   always_comb begin
      mreq        = '0;
      mreq.typ    = preq.typ;
      mreq.opaque = preq.opaque;
      if (preq.typ == 3'd0) begin
         mreq.addr = preq.addr & line_mask;
      end else begin
         // A processor len of zero means a full word, which is not a full line on this side.
         mreq.addr = preq.addr;
         mreq.len  = (preq.len == '0) ? mlw'(proc_data_nbits / 8) : mlw'(preq.len);
         mreq.data = mem_data_nbits'(preq.data);
      end
   end

   always_comb begin
      presp        = '0;
      presp.typ    = mresp.typ;
      presp.opaque = mresp.opaque;
      presp.len    = plen_q[rd_ptr];
      if (mresp.typ == 3'd0)
         presp.data = proc_data_nbits'(mresp.data >> (head_off * proc_data_nbits));
   end

   assign bus.mem_req_msg   = mreq;
   assign bus.proc_resp_msg = presp;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{pw{1'b0}}, push} - {{pw{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         off_q[wr_ptr]  <= req_off;
         plen_q[wr_ptr] <= preq.len;
      end
   end

   assign num_outstanding = count;
endmodule

// File: tb/tb_plab5_mcore_proc2mem_trans_buf.sv
// tb/tb_plab5_mcore_proc2mem_trans_buf.sv - scoreboard bench for the proc-to-mem translator with a line memory model
module tb_plab5_mcore_proc2mem_trans_buf;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] num_out;
   int         n_checks = 0;
   int         n_pass = 0;

   plab5_mcore_proc2mem_trans_buf_if bus();

   plab5_mcore_proc2mem_trans_buf dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .num_outstanding (num_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  typ;
      logic [7:0]  op;
      logic [31:0] addr;
      logic [1:0]  len;
   } req_info_t;

   logic [174:0] exp_mreq_q  [$];
   logic [44:0]  exp_presp_q [$];
   req_info_t    model_q     [$];
   req_info_t    cur_req;

   function automatic void check(string name, logic [191:0] act, logic [191:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // Line memory view of a request: reads fetch the whole aligned 16-byte line.
   function automatic logic [174:0] ref_mem_req(logic [2:0] t, logic [7:0] op, logic [31:0] addr,
                                                logic [1:0] len, logic [31:0] data);
      logic [31:0]  a;
      logic [3:0]   l;
      logic [127:0] d;
      if (t == 3'd0) begin
         a = addr - (addr % 32'd16);
         l = 4'd0;
         d = 128'd0;
      end else begin
         a = addr;
         l = (len == 2'd0) ? 4'd4 : {2'b00, len};
         d = {96'd0, data};
      end
      return {t, op, a, l, d};
   endfunction

   function automatic logic [44:0] ref_proc_resp(req_info_t r, logic [127:0] line);
      logic [31:0] w;
      int          idx;
      idx = int'((r.addr / 32'd4) % 32'd4);
      w   = (r.typ == 3'd0) ? line[idx*32 +: 32] : 32'd0;
      return {r.typ, r.op, r.len, w};
   endfunction

   task automatic present_req(logic [2:0] t, logic [7:0] op, logic [31:0] addr, logic [1:0] len, logic [31:0] data);
      exp_mreq_q.push_back(ref_mem_req(t, op, addr, len, data));
      cur_req          = '{t, op, addr, len};
      bus.proc_req_msg = {t, op, addr, len, data};
      bus.proc_req_val = 1'b1;
   endtask

   task automatic wait_req_fire(input bit rand_rdy);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.proc_req_rdy) begin
            done = 1'b1;
            model_q.push_back(cur_req);
         end
         @(posedge clk); #1;
         if (rand_rdy && !done) bus.mem_req_rdy = ($urandom_range(0, 3) != 0);
      end
      bus.proc_req_val = 1'b0;
      bus.mem_req_rdy  = 1'b1;
      if (!done) check("req_timeout", 1, 0);
   endtask

   task automatic present_resp(logic [127:0] line);
      req_info_t r;
      r = model_q[0];
      exp_presp_q.push_back(ref_proc_resp(r, line));
      bus.mem_resp_msg = {r.typ, r.op, 4'd0, line};
      bus.mem_resp_val = 1'b1;
   endtask

   task automatic wait_resp_fire(input bit rand_rdy);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.mem_resp_rdy) begin
            done = 1'b1;
            void'(model_q.pop_front());
         end
         @(posedge clk); #1;
         if (rand_rdy && !done) bus.proc_resp_rdy = ($urandom_range(0, 3) != 0);
      end
      bus.mem_resp_val  = 1'b0;
      bus.proc_resp_rdy = 1'b1;
      if (!done) check("resp_timeout", 1, 0);
   endtask

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      if (bus.mem_req_val && bus.mem_req_rdy) begin
         if (exp_mreq_q.size() == 0) check("mem_req_unexpected", 1, 0);
         else check("mem_req_msg", bus.mem_req_msg, exp_mreq_q.pop_front());
      end
      if (bus.proc_resp_val && bus.proc_resp_rdy) begin
         if (exp_presp_q.size() == 0) check("proc_resp_unexpected", 1, 0);
         else check("proc_resp_msg", bus.proc_resp_msg, exp_presp_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] line;
      logic [2:0]   t;
      int           r;

      bus.proc_req_val  = 1'b1;
      bus.proc_req_msg  = '0;
      bus.mem_req_rdy   = 1'b1;
      bus.mem_resp_val  = 1'b1;
      bus.mem_resp_msg  = '0;
      bus.proc_resp_rdy = 1'b1;

      @(negedge clk);
      check("reset_vals_rdys", {bus.mem_req_val, bus.proc_req_rdy, bus.mem_resp_rdy, bus.proc_resp_val}, 0);
      @(posedge clk); @(posedge clk); #1;
      reset            = 1'b1;
      bus.proc_req_val = 1'b0;
      bus.mem_resp_val = 1'b0;
      @(negedge clk);
      check("post_reset_count", num_out, 0);
      check("post_reset_resp_val", bus.proc_resp_val, 0);
      check("post_reset_req_rdy_hi", bus.proc_req_rdy, 1);
      @(posedge clk); #1;
      bus.mem_req_rdy = 1'b0;
      @(negedge clk);
      check("post_reset_req_rdy_lo", bus.proc_req_rdy, 0);
      @(posedge clk); #1;
      bus.mem_req_rdy = 1'b1;

      present_req(3'd0, 8'h05, 32'h0000_1008, 2'd0, 32'd0);
      wait_req_fire(0);
      present_resp(128'h44444444_33333333_22222222_11111111);
      wait_resp_fire(0);

      present_req(3'd1, 8'h06, 32'h0000_2004, 2'd0, 32'hDEAD_BEEF);
      wait_req_fire(0);
      present_resp(rand_line());
      wait_resp_fire(0);

      for (int k = 0; k < 4; k++) begin
         present_req(3'd0, 8'(k + 8'h30), 32'h3000 + 32'(4 * k), 2'($urandom), 32'd0);
         wait_req_fire(0);
      end
      bus.proc_req_val = 1'b1;
      @(negedge clk);
      check("full_count", num_out, 4);
      check("full_blocks", {bus.proc_req_rdy, bus.mem_req_val}, 0);
      @(posedge clk); #1;
      bus.proc_req_val = 1'b0;
      for (int k = 0; k < 4; k++) begin
         present_resp(rand_line());
         wait_resp_fire(0);
      end
      @(negedge clk);
      check("drained_count", num_out, 0);
      @(posedge clk); #1;

      line             = rand_line();
      bus.mem_resp_msg = {3'd0, 8'h44, 4'd0, line};
      bus.mem_resp_val = 1'b1;
      @(negedge clk);
      check("empty_stall", {bus.mem_resp_rdy, bus.proc_resp_val}, 0);
      @(posedge clk); #1;
      present_req(3'd0, 8'h44, 32'h0000_400C, 2'd0, 32'd0);
      wait_req_fire(0);
      present_resp(line);
      @(negedge clk);
      check("accept_after_push", bus.mem_resp_rdy, 1);
      if (bus.mem_resp_rdy) void'(model_q.pop_front());
      @(posedge clk); #1;
      bus.mem_resp_val = 1'b0;

      present_req(3'd0, 8'h55, 32'h0000_5004, 2'd2, 32'd0);
      wait_req_fire(0);
      bus.proc_resp_rdy = 1'b0;
      present_resp(rand_line());
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("backpressure_hold", {bus.mem_resp_rdy, num_out}, {1'b0, 3'd1});
         @(posedge clk); #1;
      end
      bus.proc_resp_rdy = 1'b1;
      wait_resp_fire(0);
      @(negedge clk);
      check("single_pop", num_out, 0);
      @(posedge clk); #1;

      present_req(3'd0, 8'h66, 32'h0000_6000, 2'd0, 32'd0);
      wait_req_fire(0);
      present_resp(rand_line());
      present_req(3'd1, 8'h67, 32'h0000_6008, 2'd1, 32'h1234_5678);
      @(negedge clk);
      check("push_pop_both", {bus.proc_req_rdy, bus.mem_resp_rdy}, 2'b11);
      if (bus.mem_resp_rdy) void'(model_q.pop_front());
      if (bus.proc_req_rdy) model_q.push_back(cur_req);
      @(posedge clk); #1;
      bus.proc_req_val = 1'b0;
      bus.mem_resp_val = 1'b0;
      @(negedge clk);
      check("push_pop_count", num_out, 1);
      @(posedge clk); #1;
      present_resp(rand_line());
      wait_resp_fire(0);

      present_req(3'd0, 8'h70, 32'h0000_7000, 2'd0, 32'd0);
      wait_req_fire(0);
      present_req(3'd0, 8'h71, 32'h0000_7004, 2'd0, 32'd0);
      wait_req_fire(0);
      reset             = 1'b0;
      bus.proc_req_val  = 1'b1;
      bus.mem_resp_val  = 1'b1;
      bus.mem_resp_msg  = '0;
      @(negedge clk);
      check("in_reset_vals_rdys", {bus.mem_req_val, bus.proc_req_rdy, bus.mem_resp_rdy, bus.proc_resp_val}, 0);
      @(negedge clk);
      check("reset_clears_count", num_out, 0);
      @(posedge clk); #1;
      reset            = 1'b1;
      bus.proc_req_val = 1'b0;
      bus.mem_resp_val = 1'b0;
      model_q.delete();
      present_req(3'd0, 8'h77, 32'h0000_7004, 2'd1, 32'd0);
      wait_req_fire(0);
      present_resp(rand_line());
      wait_resp_fire(0);

      for (int it = 0; it < 300; it++) begin
         if (model_q.size() < 4 && (model_q.size() == 0 || $urandom_range(0, 1) == 1)) begin
            r = $urandom_range(0, 7);
            t = (r < 4) ? 3'd0 : ((r < 7) ? 3'd1 : 3'd2);
            present_req(t, 8'($urandom), $urandom, 2'($urandom), $urandom);
            wait_req_fire(1);
         end else begin
            present_resp(rand_line());
            wait_resp_fire(1);
         end
      end
      while (model_q.size() > 0) begin
         present_resp(rand_line());
         wait_resp_fire(1);
      end

      @(negedge clk);
      check("final_count", num_out, 0);
      check("mem_req_queue_drained", exp_mreq_q.size(), 0);
      check("proc_resp_queue_drained", exp_presp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
